fnn_layer_seq: RTL

- Sequences one fully-connected layer of neurons.
- Buffers an input vector from the upstream stream, then broadcasts it as a contiguous burst on the shared neuron input bus.
- Collects every neuron's output/outvalid pulse, then serialises the layer results downstream as a valid/ready stream with a last flag.
- One instance sits between consecutive layers; it is the glue that chains neuron arrays into a network.

---
 rtl/fnn_layer_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fnn_layer_seq.sv
// Layer sequencer: buffers one input vector, broadcasts it to a neuron array, collects results, streams them out.
// Optional FNN_SEQ_TIMEOUT_EN bounds the WAIT state and flags err when a neuron never answers.
module fnn_layer_seq #(
  parameter int NUM_INPUTS     = 30,
  parameter int NUM_NEURONS    = 30,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             nrn_data,
  output logic                              nrn_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]            nrn_outvalid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              err
);

  localparam int IW = $clog2(NUM_INPUTS + 1);
  localparam int NW = $clog2(NUM_NEURONS + 1);
  localparam logic [IW-1:0] IN_LAST  = IW'(NUM_INPUTS - 1);
  localparam logic [IW-1:0] IN_END   = IW'(NUM_INPUTS);
  localparam logic [NW-1:0] NRN_LAST = NW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {LOAD, FEED, WAIT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] buffer [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] cap [NUM_NEURONS];
  logic [DATA_WIDTH-1:0] cap_nxt [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] cv, cv_nxt;

  logic [IW-1:0] in_cnt, in_cnt_nxt;
  logic [IW-1:0] feed_cnt, feed_cnt_nxt;
  logic [NW-1:0] out_idx, out_idx_nxt, idx_inc;

  logic                  wr_en, go_drain;
  logic                  in_ready_nxt, nrn_valid_nxt, out_valid_nxt, out_last_nxt, busy_nxt;
  logic [DATA_WIDTH-1:0] nrn_data_nxt, out_data_nxt;

`ifdef FNN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic          err_nxt;
`else
  assign err = 1'b0;
`endif

  // Slots that never reported (timeout path) are emitted as zero.
  function automatic logic [DATA_WIDTH-1:0] slot(input logic vld, input logic [DATA_WIDTH-1:0] val);
    return vld ? val : '0;
  endfunction

  always_comb begin
    state_nxt     = state;
    in_cnt_nxt    = in_cnt;
    feed_cnt_nxt  = feed_cnt;
    out_idx_nxt   = out_idx;
    idx_inc       = out_idx + NW'(1);
    cap_nxt       = cap;
    cv_nxt        = cv;
    wr_en         = 1'b0;
    go_drain      = 1'b0;
    in_ready_nxt  = 1'b0;
    nrn_valid_nxt = 1'b0;
    nrn_data_nxt  = nrn_data;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
`ifdef FNN_SEQ_TIMEOUT_EN
    wait_cnt_nxt  = wait_cnt;
    err_nxt       = err;
`endif

    if (state == FEED || state == WAIT) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (nrn_outvalid[k] && !cv[k]) begin
          cap_nxt[k] = nrn_out[k*DATA_WIDTH +: DATA_WIDTH];
          cv_nxt[k]  = 1'b1;
        end
      end
    end

    case (state)
      LOAD: begin
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          if (in_cnt == IN_LAST) begin
            state_nxt     = FEED;
            in_cnt_nxt    = '0;
            in_ready_nxt  = 1'b0;
            nrn_valid_nxt = 1'b1;
            // A single-element vector is still in flight to the buffer this cycle.
            nrn_data_nxt  = (NUM_INPUTS == 1) ? in_data : buffer[0];
            feed_cnt_nxt  = IW'(1);
          end else begin
            in_cnt_nxt = in_cnt + IW'(1);
          end
        end
      end
      FEED: begin
        if (feed_cnt == IN_END) begin
          state_nxt    = WAIT;
          feed_cnt_nxt = '0;
        end else begin
          nrn_valid_nxt = 1'b1;
          nrn_data_nxt  = buffer[feed_cnt];
          feed_cnt_nxt  = feed_cnt + IW'(1);
        end
      end
      WAIT: begin
        if (&cv_nxt) begin
          go_drain = 1'b1;
        end
`ifdef FNN_SEQ_TIMEOUT_EN
        else if (wait_cnt == TO_LAST) begin
          go_drain = 1'b1;
          err_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + TW'(1);
        end
        if (go_drain) wait_cnt_nxt = '0;
`endif
        if (go_drain) begin
          state_nxt     = DRAIN;
          out_idx_nxt   = '0;
          out_valid_nxt = 1'b1;
          out_data_nxt  = slot(cv_nxt[0], cap_nxt[0]);
          out_last_nxt  = (NUM_NEURONS == 1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt     = LOAD;
            out_idx_nxt   = '0;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            out_data_nxt  = '0;
            in_ready_nxt  = 1'b1;
            cv_nxt        = '0;
          end else begin
            out_idx_nxt  = idx_inc;
            out_data_nxt = slot(cv[idx_inc], cap[idx_inc]);
            out_last_nxt = (idx_inc == NRN_LAST);
          end
        end
      end
      default: state_nxt = LOAD;
    endcase

    busy_nxt = (state_nxt != LOAD);
  end

  always_ff @(posedge clk) begin
    if (wr_en) buffer[in_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      in_cnt    <= '0;
      feed_cnt  <= '0;
      out_idx   <= '0;
      cv        <= '0;
      in_ready  <= 1'b0;
      nrn_valid <= 1'b0;
      nrn_data  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) cap[k] <= '0;
`ifdef FNN_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      in_cnt    <= in_cnt_nxt;
      feed_cnt  <= feed_cnt_nxt;
      out_idx   <= out_idx_nxt;
      cv        <= cv_nxt;
      in_ready  <= in_ready_nxt;
      nrn_valid <= nrn_valid_nxt;
      nrn_data  <= nrn_data_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      for (int k = 0; k < NUM_NEURONS; k++) cap[k] <= cap_nxt[k];
`ifdef FNN_SEQ_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nxt;
      err       <= err_nxt;
`endif
    end
  end

endmodule
